count_prog: RTL and testbench

//   Parametrised programmable counter, next generation of the 16-bit loadable counter.
//   - Adds up/down direction, a programmable terminal value (limit) and three end-of-count modes.
//   - Adds a built-in clock-enable prescaler and terminal-count/done status outputs.
//   - Serves as the general timer/event-counter primitive for the datapath and its testbenches.

---
 rtl/count_pkg.sv | 13 +
 rtl/count_prescale.sv | 39 +++
 rtl/count_prog.sv | 91 +++++++++
 tb/tb_count_prog.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared constants for the programmable counter family.
// Holds end-of-count mode encodings and default parameter values.
package count_pkg;

    localparam logic [1:0] CNT_WRAP    = 2'b00;
    localparam logic [1:0] CNT_SAT     = 2'b01;
    localparam logic [1:0] CNT_ONESHOT = 2'b10;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_PRESCALE = 1;
    localparam int DEF_PS_W     = 8;

endpackage

// File: rtl/count_prescale.sv
// Clock-enable prescaler: emits tick once every PRESCALE enabled cycles.
// Ports: clk, resetb (async low), en (advance), clr (sync clear) -> tick.
module count_prescale #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 8
) (
    input  logic clk,
    input  logic resetb,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // With PRESCALE=1 the counter never leaves 0, so tick is constant 1.
    assign tick = (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (clr) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/count_prog.sv
// Programmable up/down counter with limit, WRAP/SAT/ONESHOT modes, prescaler.
// Ports: c_in/load, en, up, mode, limit in; c_out, tc pulse, sticky done out.
module count_prog
    import count_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int PS_W     = DEF_PS_W
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] c_in,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] c_out,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_d;
    logic             tc_q;
    logic             tc_d;
    logic             done_q;
    logic             done_d;

    logic             tick;
    logic             term_hit;
    logic [WIDTH-1:0] term_val;
    logic             sat_hold;

    count_prescale #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_ps (
        .clk    (clk),
        .resetb (resetb),
        .en     (en),
        .clr    (load),
        .tick   (tick)
    );

    // Counting up, anything at or beyond limit is treated as terminal.
    assign term_hit = up ? (c_q >= limit) : (c_q == '0);
    assign term_val = up ? limit : '0;

    always_comb begin
        c_d      = c_q;
        tc_d     = 1'b0;
        done_d   = done_q;
        sat_hold = 1'b0;
        if (load) begin
            c_d    = c_in;
            done_d = 1'b0;
        end else if (en && tick && !done_q) begin
            if (!term_hit) begin
                c_d = up ? c_q + WIDTH'(1) : c_q - WIDTH'(1);
            end else begin
                case (mode)
                    CNT_SAT, CNT_ONESHOT: sat_hold = 1'b1;
                    default:              c_d = up ? '0 : limit;
                endcase
            end
            // A hold at terminal is not a new arrival, so no pulse.
            tc_d = !sat_hold && (c_d == term_val);
            if (tc_d && mode == CNT_ONESHOT) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            c_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign c_out = c_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_count_prog.sv
// Bench for count_prog: two instances (PRESCALE 1 and 4) on shared stimulus.
// Reference model predictions are queued and compared by a monitor process.
module tb_count_prog;

    logic        clk = 1'b0;
    logic        resetb;
    logic [15:0] c_in;
    logic [15:0] limit;
    logic        load;
    logic        en;
    logic        up;
    logic [1:0]  mode;
    logic [15:0] c_a;
    logic [15:0] c_b;
    logic        tc_a;
    logic        tc_b;
    logic        dn_a;
    logic        dn_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_prog #(.WIDTH(16), .PRESCALE(1), .PS_W(8)) dut_a (
        .clk(clk), .resetb(resetb), .c_in(c_in), .load(load), .en(en),
        .up(up), .mode(mode), .limit(limit),
        .c_out(c_a), .tc(tc_a), .done(dn_a)
    );

    count_prog #(.WIDTH(16), .PRESCALE(4), .PS_W(8)) dut_b (
        .clk(clk), .resetb(resetb), .c_in(c_in), .load(load), .en(en),
        .up(up), .mode(mode), .limit(limit),
        .c_out(c_b), .tc(tc_b), .done(dn_b)
    );

    typedef struct {
        int c0;
        int c1;
        bit t0;
        bit t1;
        bit d0;
        bit d1;
    } exp_t;

    exp_t q[$];

    int mc[2];
    int mps[2];
    bit mdn[2];
    bit mtc[2];
    int pres[2] = '{1, 4};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mps[k] = 0; mdn[k] = 0; mtc[k] = 0;
        end
    endtask

    // Behaviour of one counter across one clock edge, from the rules.
    task automatic model(input int k);
        int p;
        int nc;
        int term;
        bit at;
        bit tick;
        bit hold;
        p = pres[k];
        mtc[k] = 0;
        if (load) begin
            mc[k] = int'(c_in); mdn[k] = 0; mps[k] = 0;
            return;
        end
        if (!en) return;
        tick = (mps[k] == p - 1);
        mps[k] = tick ? 0 : mps[k] + 1;
        if (!tick || mdn[k]) return;
        term = up ? int'(limit) : 0;
        at = up ? (mc[k] >= int'(limit)) : (mc[k] == 0);
        hold = 0;
        if (!at) nc = up ? (mc[k] + 1) % 65536 : (mc[k] + 65535) % 65536;
        else if (mode == 2'd1 || mode == 2'd2) begin nc = mc[k]; hold = 1; end
        else nc = up ? 0 : int'(limit);
        mtc[k] = !hold && (nc == term);
        if (mtc[k] && mode == 2'd2) mdn[k] = 1;
        mc[k] = nc;
    endtask

    task automatic cyc(input bit ld, input int ci, input bit e, input bit u,
                       input int md, input int lim);
        exp_t x;
        @(negedge clk);
        load = ld; c_in = ci[15:0]; en = e; up = u;
        mode = md[1:0]; limit = lim[15:0];
        if (resetb) begin
            model(0);
            model(1);
            x.c0 = mc[0]; x.c1 = mc[1];
            x.t0 = mtc[0]; x.t1 = mtc[1];
            x.d0 = mdn[0]; x.d1 = mdn[1];
            q.push_back(x);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sb_c_p1", 32'(c_a), 32'(x.c0));
            chk("sb_tc_p1", 32'(tc_a), 32'(x.t0));
            chk("sb_done_p1", 32'(dn_a), 32'(x.d0));
            chk("sb_c_p4", 32'(c_b), 32'(x.c1));
            chk("sb_tc_p4", 32'(tc_b), 32'(x.t1));
            chk("sb_done_p4", 32'(dn_b), 32'(x.d1));
        end
    end

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int ntc;
        resetb = 1'b0;
        load = 0; en = 0; up = 0; mode = 0; c_in = 0; limit = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_c", 32'(c_a), 0);
        chk("reset_tc_done", 32'({tc_a, dn_a, tc_b, dn_b}), 0);
        resetb = 1'b1;

        // Count to 0x0123 then drop reset in the middle of a cycle.
        cyc(1, 16'h0120, 0, 1, 0, 16'hffff);
        repeat (3) cyc(0, 0, 1, 1, 0, 16'hffff);
        sample();
        chk("pre_reset_c", 32'(c_a), 32'h0123);
        #1;
        resetb = 1'b0;
        model_reset();
        #1;
        chk("async_c", 32'({c_a, c_b}), 0);
        chk("async_flags", 32'({tc_a, dn_a, tc_b, dn_b}), 0);
        @(negedge clk);
        en = 0;
        @(negedge clk);
        resetb = 1'b1;
        repeat (2) cyc(0, 0, 1, 1, 0, 16'hffff);
        sample();
        chk("resume_c", 32'(c_a), 2);

        // Full-width wrap at the top of the range.
        cyc(1, 16'hfff0, 0, 1, 0, 16'hffff);
        repeat (15) cyc(0, 0, 1, 1, 0, 16'hffff);
        sample();
        chk("top_c", 32'(c_a), 32'hffff);
        chk("top_tc", 32'(tc_a), 1);
        cyc(0, 0, 1, 1, 0, 16'hffff);
        sample();
        chk("top_wrap", 32'(c_a), 0);

        // limit 9 wrap: tc once per 10 steps, only at 9.
        cyc(1, 0, 0, 1, 0, 9);
        ntc = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(0, 0, 1, 1, 0, 9);
            sample();
            if (tc_a) begin
                ntc++;
                chk("lim9_tc_at9", 32'(c_a), 9);
            end
        end
        chk("lim9_tc_count", 32'(ntc), 2);
        chk("lim9_final", 32'(c_a), 5);

        // Saturating down count from 3.
        cyc(1, 3, 0, 0, 1, 9);
        ntc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 1, 9);
            sample();
            chk("sat_c", 32'(c_a), (i < 3) ? 2 - i : 0);
            if (tc_a) ntc++;
        end
        chk("sat_tc_count", 32'(ntc), 1);

        // Oneshot with prescale 4 reaches 5 after 20 cycles.
        cyc(1, 0, 0, 1, 2, 5);
        for (int i = 1; i <= 24; i++) begin
            cyc(0, 0, 1, 1, 2, 5);
            sample();
            if (i == 20) begin
                chk("os_c20", 32'(c_b), 5);
                chk("os_tc20", 32'({tc_b, dn_b}), 32'h3);
            end
        end
        chk("os_frozen", 32'({c_b, tc_b, dn_b}), {16'd5, 2'b01});
        cyc(1, 0, 0, 1, 2, 5);
        sample();
        chk("os_clear", 32'({c_b, dn_b}), 0);

        // Load beats step; tc is never raised by a load.
        cyc(1, 9, 1, 1, 0, 9);
        sample();
        chk("ld_c", 32'(c_a), 9);
        chk("ld_tc", 32'(tc_a), 0);
        cyc(0, 0, 1, 1, 0, 9);
        sample();
        chk("ld_next", 32'(c_a), 0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            bit ld;
            int ci;
            int lim;
            ld = ($urandom_range(0, 15) == 0);
            ci = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 24));
            lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 20));
            cyc(ld, ci, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                int'($urandom_range(0, 3)), lim);
        end

        @(negedge clk);
        load = 0; en = 0;
        repeat (4) @(posedge clk);
        #3;
        chk("sb_drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
